// File: rtl/decode_stage.sv
// Decode pipeline stage: register-file read with write-through bypass, control
// generation, load-use interlock, and branch flush in front of Execute.
module decode_stage #(
    parameter int          CNTRL_W  = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               fetch_valid,
    output logic               fetch_ready,
    input  logic [31:0]        fetch_pc,
    input  logic [31:0]        fetch_insn,
    input  logic               wb_en,
    input  logic [4:0]         wb_addr,
    input  logic [31:0]        wb_data,
    input  logic               ex_ready,
    input  logic               ex_flush,
    output logic               valid,
    output logic [31:0]        pc,
    output logic [31:0]        rs,
    output logic [31:0]        rt,
    output logic [31:0]        insn,
    output logic [CNTRL_W-1:0] control,
    output logic [4:0]         dest,
    output logic               illegal
);

    localparam int C_ALUINB = 0;
    localparam int C_ALUOP  = 1;
    localparam int C_BR     = 2;
    localparam int C_JP     = 3;
    localparam int C_MEMRD  = 4;
    localparam int C_MEMWR  = 5;
    localparam int C_REGWR  = 6;
    localparam int C_REGDST = 7;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    logic [31:0]        r_regs [32];
    logic               r_valid;
    logic [31:0]        r_pc;
    logic [31:0]        r_rs;
    logic [31:0]        r_rt;
    logic [31:0]        r_insn;
    logic [CNTRL_W-1:0] r_control;
    logic [4:0]         r_dest;
    logic               r_illegal;

    logic [5:0]         w_op;
    logic [5:0]         w_func;
    logic [4:0]         w_rs_idx;
    logic [4:0]         w_rt_idx;
    logic [CNTRL_W-1:0] w_ctrl;
    logic [4:0]         w_dest;
    logic               w_ill;
    logic               w_reads_rt;
    logic [31:0]        w_rs_val;
    logic [31:0]        w_rt_val;
    logic               w_hold;
    logic               w_load_use;
    logic               w_ready;
    logic               w_xfer;

    assign w_op     = fetch_insn[31:26];
    assign w_func   = fetch_insn[5:0];
    assign w_rs_idx = fetch_insn[25:21];
    assign w_rt_idx = fetch_insn[20:16];

    always_comb begin
        w_ctrl     = '0;
        w_dest     = 5'd0;
        w_ill      = 1'b0;
        w_reads_rt = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                w_reads_rt = 1'b1;
                if (w_func == FN_JR) begin
                    w_ctrl[C_JP] = 1'b1;
                end else begin
                    w_ctrl[C_ALUOP]  = 1'b1;
                    w_ctrl[C_REGWR]  = 1'b1;
                    w_ctrl[C_REGDST] = 1'b1;
                    w_dest           = fetch_insn[15:11];
                end
            end
            OP_ADDI, OP_ADDIU: begin
                w_ctrl[C_ALUINB] = 1'b1;
                w_ctrl[C_REGWR]  = 1'b1;
                w_dest           = w_rt_idx;
            end
            OP_LW: begin
                w_ctrl[C_ALUINB] = 1'b1;
                w_ctrl[C_MEMRD]  = 1'b1;
                w_ctrl[C_REGWR]  = 1'b1;
                w_dest           = w_rt_idx;
            end
            OP_SW: begin
                w_reads_rt       = 1'b1;
                w_ctrl[C_ALUINB] = 1'b1;
                w_ctrl[C_MEMWR]  = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                w_reads_rt    = 1'b1;
                w_ctrl[C_BR]  = 1'b1;
            end
            OP_J: begin
                w_ctrl[C_JP] = 1'b1;
            end
            OP_JAL: begin
                w_ctrl[C_JP]    = 1'b1;
                w_ctrl[C_REGWR] = 1'b1;
                w_dest          = 5'd31;
            end
            default: w_ill = 1'b1;
        endcase
    end

    // Writeback in the same cycle is forwarded so the decoded operand is never stale.
    always_comb begin
        if (w_rs_idx == 5'd0)
            w_rs_val = 32'd0;
        else if (wb_en && (wb_addr == w_rs_idx))
            w_rs_val = wb_data;
        else
            w_rs_val = r_regs[w_rs_idx];

        if (w_rt_idx == 5'd0)
            w_rt_val = 32'd0;
        else if (wb_en && (wb_addr == w_rt_idx))
            w_rt_val = wb_data;
        else
            w_rt_val = r_regs[w_rt_idx];
    end

    assign w_hold     = r_valid & ~ex_ready;
    assign w_load_use = r_valid & r_control[C_MEMRD] & (r_dest != 5'd0) & fetch_valid &
                        ((w_rs_idx == r_dest) | (w_reads_rt & (w_rt_idx == r_dest)));
    assign w_ready    = ~reset & ~ex_flush & ~w_hold & ~w_load_use;
    assign w_xfer     = fetch_valid & w_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 32; k++) r_regs[k] <= 32'd0;
        end else if (wb_en && (wb_addr != 5'd0)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // The interlock bubble falls out of the final else: stalled fetch, Execute drains.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_pc      <= RESET_PC;
            r_rs      <= 32'd0;
            r_rt      <= 32'd0;
            r_insn    <= 32'd0;
            r_control <= '0;
            r_dest    <= 5'd0;
            r_illegal <= 1'b0;
        end else if (ex_flush) begin
            r_valid <= 1'b0;
        end else if (w_hold) begin
            r_valid <= r_valid;
        end else if (w_xfer) begin
            r_valid   <= 1'b1;
            r_pc      <= fetch_pc;
            r_rs      <= w_rs_val;
            r_rt      <= w_rt_val;
            r_insn    <= fetch_insn;
            r_control <= w_ctrl;
            r_dest    <= w_dest;
            r_illegal <= w_ill;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign fetch_ready = w_ready;
    assign valid       = r_valid;
    assign pc          = r_pc;
    assign rs          = r_rs;
    assign rt          = r_rt;
    assign insn        = r_insn;
    assign control     = r_control;
    assign dest        = r_dest;
    assign illegal     = r_illegal;

endmodule
